ysyx_23060201_lsu: RTL and testbench

Load/store unit sitting between the execute stage and the DPI-backed data memory block, which consumes its write port. Accepts one memory operation at a time over a valid/ready handshake, drives a word-aligned write port (address, data, 8-bit byte mask, one-cycle enable) and a word-aligned read port, and returns load data, aligned and extended, to writeback. A multi-cycle FSM with a latency counter models memory delay.

---
 rtl/ysyx_23060201_lsu_pkg.sv | 36 +++
 rtl/ysyx_23060201_lsu_if.sv | 44 ++++
 rtl/ysyx_23060201_lsu_align.sv | 50 +++++
 rtl/ysyx_23060201_lsu.sv | 123 ++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 width
// codes, store mask bases and request decode helpers.
package ysyx_23060201_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic f3_valid(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_if.sv
// Request, response and data-memory port bundle of the load/store unit.
// The LSU is the slave; execute/writeback/memory side is the master.
interface ysyx_23060201_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_load;
    logic                  in_is_store;
    logic [2:0]            in_funct3;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic [4:0]            in_rd;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_rdata;
    logic [4:0]            out_rd;
    logic                  out_misalign;

    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        output out_ready, mem_rdata,
        input  in_ready, out_valid, out_rdata, out_rd, out_misalign,
        input  mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_ren, mem_raddr
    );

    modport slave (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        input  out_ready, mem_rdata,
        output in_ready, out_valid, out_rdata, out_rd, out_misalign,
        output mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_ren, mem_raddr
    );

endinterface

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational byte-lane steering: store data/mask placement within the word
// and load byte/half extraction with sign or zero extension.
module ysyx_23060201_lsu_align
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] st_raw,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic [3:0]            st_mask,
    input  logic [DATA_WIDTH-1:0] ld_word,
    output logic [DATA_WIDTH-1:0] ld_data
);
    logic [4:0]            sh;
    logic [3:0]            base;
    logic [7:0]            mask_wide;
    logic [DATA_WIDTH-1:0] ld_sh;

    assign sh        = {off, 3'b000};
    assign st_data   = st_raw << sh;
    assign mask_wide = {4'b0000, base} << off;
    // Lanes shifted past byte 3 are dropped, giving the truncated mask on a
    // misaligned access.
    assign st_mask   = mask_wide[3:0];
    assign ld_sh     = ld_word >> sh;

    always_comb begin
        base = MASK_W;
        case (funct3[1:0])
            2'b00:   base = MASK_B;
            2'b01:   base = MASK_H;
            default: base = MASK_W;
        endcase
    end

    always_comb begin
        ld_data = '0;
        case (funct3)
            F3_B:    ld_data = {{(DATA_WIDTH-8){ld_sh[7]}}, ld_sh[7:0]};
            F3_BU:   ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_sh[7:0]};
            F3_H:    ld_data = {{(DATA_WIDTH-16){ld_sh[15]}}, ld_sh[15:0]};
            F3_HU:   ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_sh[15:0]};
            F3_W:    ld_data = ld_sh;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
// Define YSYX_23060201_LSU_MISALIGN_EN to trap misaligned ops instead of issuing them.
module ysyx_23060201_lsu
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_23060201_lsu_if.slave    bus
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    lsu_state_e            state_q, state_d;
    logic [3:0]            cnt_q;
    logic                  is_load_q, is_store_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [4:0]            rd_q;

    logic                  req_store, req_load, req_mem, req_go;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic [DATA_WIDTH-1:0] st_data, ld_data;
    logic [3:0]            st_mask;

    // Load+store together is treated as a store.
    assign req_store = bus.in_is_store;
    assign req_load  = bus.in_is_load & ~bus.in_is_store;
    assign req_mem   = (req_store | req_load) & f3_valid(bus.in_funct3);

`ifdef YSYX_23060201_LSU_MISALIGN_EN
    logic req_mis, misalign_q;
    assign req_mis = req_mem & f3_misalign(bus.in_funct3, bus.in_addr[1:0]);
    assign req_go  = req_mem & ~req_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (state_q == ST_IDLE && bus.in_valid)
            misalign_q <= req_mis;
    end
    assign bus.out_misalign = misalign_q;
`else
    assign req_go           = req_mem;
    assign bus.out_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.in_valid) state_d = req_go ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:   if (bus.out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.in_valid) begin
                    cnt_q      <= LAT_M1;
                    is_load_q  <= req_load & req_go;
                    is_store_q <= req_store & req_go;
                    f3_q       <= bus.in_funct3;
                    addr_q     <= bus.in_addr;
                    wdata_q    <= bus.in_wdata;
                    rd_q       <= bus.in_rd;
                    rdata_q    <= '0;
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0)  cnt_q   <= cnt_q - 4'd1;
                    else if (is_load_q) rdata_q <= ld_data;
                end
                default: ;
            endcase
        end
    end

    ysyx_23060201_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3  (f3_q),
        .off     (addr_q[1:0]),
        .st_raw  (wdata_q),
        .st_data (st_data),
        .st_mask (st_mask),
        .ld_word (bus.mem_rdata),
        .ld_data (ld_data)
    );

    assign addr_word = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // The write strobe is a single pulse on the first ACCESS cycle; the counter
    // still holds its load value there.
    assign bus.mem_wen   = (state_q == ST_ACCESS) && is_store_q && (cnt_q == LAT_M1);
    assign bus.mem_ren   = (state_q == ST_ACCESS) && is_load_q;
    assign bus.mem_waddr = bus.mem_wen ? addr_word : '0;
    assign bus.mem_wdata = bus.mem_wen ? st_data : '0;
    assign bus.mem_wmask = bus.mem_wen ? {4'b0000, st_mask} : 8'h00;
    assign bus.mem_raddr = bus.mem_ren ? addr_word : '0;

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_RESP);
    assign bus.out_rdata = rdata_q;
    assign bus.out_rd    = rd_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for the LSU at MEM_LATENCY=2; expectations are hand-derived.
module tb_ysyx_23060201_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   npass = 0;
    int   ntot  = 0;
    int   wen_cnt = 0;
    int   ren_cnt = 0;

    always #5 clk = ~clk;

    ysyx_23060201_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.mem_wen) wen_cnt++;
        if (bus.mem_ren) ren_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin step(); n++; end
        if (!bus.in_ready) begin
            ntot++;
            $display("FAIL issue_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid    = 1'b1;
        bus.in_is_load  = ld;
        bus.in_is_store = st;
        bus.in_funct3   = f3;
        bus.in_addr     = a;
        bus.in_wdata    = wd;
        bus.in_rd       = rd;
        step();
        bus.in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        ntot++;
        if ({bus.in_ready, bus.out_valid, bus.out_misalign, bus.mem_wen, bus.mem_ren} !== 5'b10000)
            $display("FAIL reset_ctl: got %b required 10000",
                     {bus.in_ready, bus.out_valid, bus.out_misalign, bus.mem_wen, bus.mem_ren});
        else npass++;
        ntot++;
        if ({bus.out_rdata, bus.out_rd, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask, bus.mem_raddr} !== '0)
            $display("FAIL reset_data: rdata=%h rd=%h waddr=%h wdata=%h wmask=%h raddr=%h required 0",
                     bus.out_rdata, bus.out_rd, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask, bus.mem_raddr);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sw();
        int w0;
        w0 = wen_cnt;
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd3);
        ntot++;
        if ({bus.mem_wen, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask} !== {1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F})
            $display("FAIL sw_port: wen=%b waddr=%h wdata=%h wmask=%h required 1 80000004 deadbeef 0f",
                     bus.mem_wen, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask);
        else npass++;
        step();
        ntot++;
        if ({bus.mem_wen, bus.mem_wmask, bus.out_valid} !== 10'b0)
            $display("FAIL sw_cycle2: wen=%b wmask=%h out_valid=%b required 0 00 0",
                     bus.mem_wen, bus.mem_wmask, bus.out_valid);
        else npass++;
        step();
        ntot++;
        if ({bus.out_valid, bus.out_rdata, bus.out_rd, bus.in_ready} !== {1'b1, 32'h0, 5'd3, 1'b0})
            $display("FAIL sw_resp: valid=%b rdata=%h rd=%0d in_ready=%b required 1 0 3 0",
                     bus.out_valid, bus.out_rdata, bus.out_rd, bus.in_ready);
        else npass++;
        step();
        ntot++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || wen_cnt - w0 != 1)
            $display("FAIL sw_done: in_ready=%b out_valid=%b wen_pulses=%0d required 1 0 1",
                     bus.in_ready, bus.out_valid, wen_cnt - w0);
        else npass++;
    endtask

    task automatic test_store_lanes();
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 5'd0);
        ntot++;
        if ({bus.mem_waddr, bus.mem_wdata, bus.mem_wmask} !== {32'h8000_0000, 32'hAB00_0000, 8'h08})
            $display("FAIL sb_lane: waddr=%h wdata=%h wmask=%h required 80000000 ab000000 08",
                     bus.mem_waddr, bus.mem_wdata, bus.mem_wmask);
        else npass++;
        step(); step(); step();
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 5'd0);
        ntot++;
        if ({bus.mem_wdata, bus.mem_wmask} !== {32'h5678_0000, 8'h0C})
            $display("FAIL sh_lane: wdata=%h wmask=%h required 56780000 0c", bus.mem_wdata, bus.mem_wmask);
        else npass++;
        step(); step(); step();
        // load+store together behaves as a store
        issue(1'b1, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_0055, 5'd9);
        ntot++;
        if ({bus.mem_wen, bus.mem_ren, bus.mem_wdata, bus.mem_wmask} !== {2'b10, 32'h0000_5500, 8'h02})
            $display("FAIL ldst_as_store: wen=%b ren=%b wdata=%h wmask=%h required 1 0 00005500 02",
                     bus.mem_wen, bus.mem_ren, bus.mem_wdata, bus.mem_wmask);
        else npass++;
        step(); step(); step();
    endtask

    task automatic load_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] word, input logic [31:0] exp);
        int r0;
        r0 = ren_cnt;
        bus.mem_rdata = word;
        issue(1'b1, 1'b0, f3, a, 32'h0, 5'd5);
        ntot++;
        if ({bus.mem_ren, bus.mem_raddr, bus.mem_wen} !== {1'b1, a & 32'hFFFF_FFFC, 1'b0})
            $display("FAIL %s_port: ren=%b raddr=%h wen=%b required 1 %h 0",
                     name, bus.mem_ren, bus.mem_raddr, bus.mem_wen, a & 32'hFFFF_FFFC);
        else npass++;
        step(); step();
        ntot++;
        if ({bus.out_valid, bus.out_rdata, bus.out_rd, bus.out_misalign} !== {1'b1, exp, 5'd5, 1'b0}
            || ren_cnt - r0 != 2)
            $display("FAIL %s_resp: valid=%b rdata=%h rd=%0d mis=%b ren_cycles=%0d required 1 %h 5 0 2",
                     name, bus.out_valid, bus.out_rdata, bus.out_rd, bus.out_misalign, ren_cnt - r0, exp);
        else npass++;
        step();
    endtask

    task automatic test_loads();
        load_check("lb",  3'b000, 32'h8000_0002, 32'h0080_0000, 32'hFFFF_FF80);
        load_check("lbu", 3'b100, 32'h8000_0002, 32'h0080_0000, 32'h0000_0080);
        load_check("lh",  3'b001, 32'h8000_0002, 32'h8001_0000, 32'hFFFF_8001);
        load_check("lhu", 3'b101, 32'h8000_0002, 32'h8001_0000, 32'h0000_8001);
    endtask

    task automatic test_misalign();
        int r0;
        r0 = ren_cnt;
        bus.mem_rdata = 32'h0080_0000;
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 5'd7);
`ifdef YSYX_23060201_LSU_MISALIGN_EN
        ntot++;
        if ({bus.out_valid, bus.out_misalign, bus.out_rdata, bus.mem_ren, bus.mem_wen} !== {2'b11, 32'h0, 2'b00})
            $display("FAIL lh_mis_trap: valid=%b mis=%b rdata=%h ren=%b wen=%b required 1 1 0 0 0",
                     bus.out_valid, bus.out_misalign, bus.out_rdata, bus.mem_ren, bus.mem_wen);
        else npass++;
        step();
        ntot++;
        if (ren_cnt != r0 || bus.in_ready !== 1'b1)
            $display("FAIL lh_mis_noread: ren_cycles=%0d in_ready=%b required 0 1", ren_cnt - r0, bus.in_ready);
        else npass++;
`else
        ntot++;
        if ({bus.mem_ren, bus.out_valid} !== 2'b10)
            $display("FAIL lh_mis_access: ren=%b valid=%b required 1 0", bus.mem_ren, bus.out_valid);
        else npass++;
        step(); step();
        ntot++;
        if ({bus.out_valid, bus.out_misalign, bus.out_rdata} !== {2'b10, 32'hFFFF_8000})
            $display("FAIL lh_mis_resp: valid=%b mis=%b rdata=%h required 1 0 ffff8000",
                     bus.out_valid, bus.out_misalign, bus.out_rdata);
        else npass++;
        step();
`endif
    endtask

    task automatic test_bypass();
        int r0;
        r0 = ren_cnt;
        issue(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd4);
        ntot++;
        if ({bus.out_valid, bus.out_rdata, bus.out_rd, bus.mem_ren} !== {1'b1, 32'h0, 5'd4, 1'b0})
            $display("FAIL bad_f3: valid=%b rdata=%h rd=%0d ren=%b required 1 0 4 0",
                     bus.out_valid, bus.out_rdata, bus.out_rd, bus.mem_ren);
        else npass++;
        step();
        issue(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 5'd6);
        ntot++;
        if ({bus.out_valid, bus.out_rd, bus.mem_wen, bus.mem_ren} !== {1'b1, 5'd6, 2'b00} || ren_cnt != r0)
            $display("FAIL nop_op: valid=%b rd=%0d wen=%b ren=%b required 1 6 0 0",
                     bus.out_valid, bus.out_rd, bus.mem_wen, bus.mem_ren);
        else npass++;
        step();
    endtask

    task automatic test_stall();
        bus.mem_rdata = 32'hCAFE_F00D;
        bus.out_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd11);
        step(); step();
        bus.mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            ntot++;
            if ({bus.out_valid, bus.in_ready, bus.out_rdata, bus.out_rd} !== {2'b10, 32'hCAFE_F00D, 5'd11})
                $display("FAIL stall_hold%0d: valid=%b in_ready=%b rdata=%h rd=%0d required 1 0 cafef00d 11",
                         i, bus.out_valid, bus.in_ready, bus.out_rdata, bus.out_rd);
            else npass++;
            step();
        end
        bus.out_ready = 1'b1;
        step();
        ntot++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL stall_release: in_ready=%b valid=%b required 1 0", bus.in_ready, bus.out_valid);
        else npass++;
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wen_cnt;
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h5555_AAAA, 5'd2);
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({bus.in_ready, bus.out_valid, bus.mem_wen, bus.mem_wmask, bus.mem_waddr, bus.out_rd} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 5'd0})
            $display("FAIL rst_mid_outs: in_ready=%b valid=%b wen=%b wmask=%h waddr=%h rd=%0d required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.mem_wen, bus.mem_wmask, bus.mem_waddr, bus.out_rd);
        else npass++;
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        ntot++;
        if (wen_cnt != w0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rst_mid_drop: wen_pulses=%0d in_ready=%b valid=%b required 0 1 0",
                     wen_cnt - w0, bus.in_ready, bus.out_valid);
        else npass++;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_is_load  = 1'b0;
        bus.in_is_store = 1'b0;
        bus.in_funct3   = 3'b000;
        bus.in_addr     = 32'h0;
        bus.in_wdata    = 32'h0;
        bus.in_rd       = 5'd0;
        bus.out_ready   = 1'b1;
        bus.mem_rdata   = 32'h0;
        test_reset();
        test_sw();
        test_store_lanes();
        test_loads();
        test_misalign();
        test_bypass();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
